ifu: RTL and testbench



---
 rtl/mips_defs.sv | 25 ++
 rtl/npc.sv | 42 ++++
 rtl/ifu.sv | 133 +++++++++++++
 tb/tb_ifu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the single-cycle MIPS datapath.
// Contents: opcode/funct constants, reset PC, halt word, and the fetch FSM state type.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_t;

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection.
// Ports:
//   i_pc          current PC
//   i_imm16       branch offset in words (sign-extended)
//   i_instr_index jump target field instr[25:0]
//   i_branch      current instruction is beq
//   i_zero        ALU equality flag
//   i_j           current instruction is j
//   o_next_pc     selected next PC (J > taken branch > sequential)
//   o_pc_plus4    i_pc + 4
module npc (
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic        i_j,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  assign w_pc_plus4  = i_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], i_instr_index, 2'b00};

  // J has priority so an illegal Branch+J combination is still deterministic.
  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_j) begin
      o_next_pc = w_j_target;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_target;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, instruction ROM, field split and run/halt FSM.
// Ports:
//   clk, reset       clock and synchronous active-low reset
//   Branch, J, zero  control from controller / ALU for the current instruction
//   pc, pc_plus4     current PC and PC + 4
//   instr            ROM word at pc (0 while halted)
//   opcode..imm16    fields of instr
//   halted           fetch FSM is in HALT
//
// state   | meaning
// ST_RUN  | PC advances to the selected next PC every cycle
// ST_HALT | PC frozen, instruction outputs forced to 0 (sll $0,$0,0)
module ifu
  import mips_defs::*;
#(
  parameter logic [31:0] PC_RESET      = mips_defs::PC_RESET,
  parameter int          IM_DEPTH_LOG2 = 10,
  parameter string       IM_FILE       = "code.txt",
  parameter logic [31:0] HALT_WORD     = mips_defs::HALT_WORD,
  // ROM image
  parameter logic [31:0] IM_INIT [2**IM_DEPTH_LOG2] = '{default: 32'h0}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch,
  input  logic        zero,
  input  logic        J,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        halted
);

  localparam int          DEPTH    = 2**IM_DEPTH_LOG2;
  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * DEPTH);

  ifu_state_t r_state;
  ifu_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset;
  logic [31:0] w_rom_word;
  logic [31:0] w_instr;
  logic [IM_DEPTH_LOG2-1:0] w_idx;
  logic        w_in_range;
  logic        w_unused_offset;

  logic [31:0] r_rom [DEPTH];

  // Static ROM image, fixed at elaboration.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_rom[i] = IM_INIT[i];
    end
  end

  // r_pc only ever holds aligned in-range addresses, so the word index is
  // simply the offset from the reset PC.
  assign w_offset        = r_pc - PC_RESET;
  assign w_idx           = w_offset[IM_DEPTH_LOG2+1:2];
  assign w_unused_offset = ^{w_offset[31:IM_DEPTH_LOG2+2], w_offset[1:0]};
  assign w_rom_word      = r_rom[w_idx];

  assign w_instr = (r_state == ST_HALT) ? 32'h0 : w_rom_word;

  npc u_npc (
    .i_pc          (r_pc),
    .i_imm16       (w_instr[15:0]),
    .i_instr_index (w_instr[25:0]),
    .i_branch      (Branch),
    .i_zero        (zero),
    .i_j           (J),
    .o_next_pc     (w_next_pc),
    .o_pc_plus4    (w_pc_plus4)
  );

  assign w_in_range = (w_next_pc >= PC_RESET) && (w_next_pc < PC_LIMIT) &&
                      (w_next_pc[1:0] == 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_RUN: begin
        // Halt word or a bad target freezes PC at the current address.
        if (w_rom_word == HALT_WORD || !w_in_range) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt = w_next_pc;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign instr    = w_instr;
  assign opcode   = w_instr[31:26];
  assign rs       = w_instr[25:21];
  assign rt       = w_instr[20:16];
  assign rd       = w_instr[15:11];
  assign shamt    = w_instr[10:6];
  assign funct    = w_instr[5:0];
  assign imm16    = w_instr[15:0];
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  localparam logic [31:0] PROG_A [1024] = '{
    0: 32'h3C01_1234,   // lui
    1: 32'h3421_5678,   // ori
    2: 32'h1000_FFFE,   // beq, offset -2 words
    3: 32'hFFFF_FFFF,   // halt
    default: 32'h0
  };

  localparam logic [31:0] PROG_B [1024] = '{
    4: 32'h0800_0C05,   // j 0x3014
    5: 32'h0800_0C08,   // j 0x3020 (imm16 as branch would go out of range)
    8: 32'h0800_1000,   // j 0x4000, past the ROM
    default: 32'h0
  };

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  logic br = 1'b0;
  logic zr = 1'b0;
  logic jp = 1'b0;

  logic [31:0] pc_a, pc4_a, instr_a, pc_b, pc4_b, instr_b;
  logic [5:0]  op_a, fn_a, op_b, fn_b;
  logic [4:0]  rs_a, rt_a, rd_a, sh_a, rs_b, rt_b, rd_b, sh_b;
  logic [15:0] im_a, im_b;
  logic        halt_a, halt_b;

  always #5 clk = ~clk;

  ifu #(.IM_FILE(""), .IM_INIT(PROG_A)) dut_a (
    .clk(clk), .reset(reset_a), .Branch(br), .zero(zr), .J(jp),
    .pc(pc_a), .pc_plus4(pc4_a), .instr(instr_a), .opcode(op_a),
    .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a), .funct(fn_a),
    .imm16(im_a), .halted(halt_a)
  );

  ifu #(.IM_FILE(""), .IM_INIT(PROG_B)) dut_b (
    .clk(clk), .reset(reset_b), .Branch(br), .zero(zr), .J(jp),
    .pc(pc_b), .pc_plus4(pc4_b), .instr(instr_b), .opcode(op_b),
    .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b), .funct(fn_b),
    .imm16(im_b), .halted(halt_b)
  );

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          halted;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input bit sel, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut_%s got %h want %h", name, sel ? "b" : "a", act, exp);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare against the queue.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.sel) begin
        check("pc", 0, pc_a, e.pc);
        check("pc_plus4", 0, pc4_a, e.pc + 32'd4);
        check("instr", 0, instr_a, e.instr);
        check("opcode", 0, {26'h0, op_a}, {26'h0, e.instr[31:26]});
        check("imm16", 0, {16'h0, im_a}, {16'h0, e.instr[15:0]});
        check("halted", 0, {31'h0, halt_a}, {31'h0, e.halted});
      end else begin
        check("pc", 1, pc_b, e.pc);
        check("pc_plus4", 1, pc4_b, e.pc + 32'd4);
        check("instr", 1, instr_b, e.instr);
        check("opcode", 1, {26'h0, op_b}, {26'h0, e.instr[31:26]});
        check("imm16", 1, {16'h0, im_b}, {16'h0, e.instr[15:0]});
        check("halted", 1, {31'h0, halt_b}, {31'h0, e.halted});
      end
    end
  end

  // Drive one cycle's inputs on the selected DUT (the other is held in reset)
  // and queue the state expected after the next rising edge.
  task automatic step(input bit sel, input bit rst, input logic b, input logic z,
                      input logic j, input logic [31:0] epc, input logic [31:0] einstr,
                      input bit ehalt);
    exp_t e;
    @(negedge clk);
    reset_a = sel ? 1'b0 : ~rst;
    reset_b = sel ? ~rst : 1'b0;
    br = b;
    zr = z;
    jp = j;
    e.sel = sel;
    e.pc = epc;
    e.instr = einstr;
    e.halted = ehalt;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic b_run_to_3020();
    step(1, 0, 0, 0, 0, 32'h3004, 32'h0, 0);
    step(1, 0, 0, 0, 0, 32'h3008, 32'h0, 0);
    step(1, 0, 0, 0, 0, 32'h300C, 32'h0, 0);
    step(1, 0, 0, 0, 0, 32'h3010, 32'h0800_0C05, 0);
    step(1, 0, 0, 0, 1, 32'h3014, 32'h0800_0C08, 0);
    // Branch and J together: J target wins
    step(1, 0, 1, 1, 1, 32'h3020, 32'h0800_1000, 0);
  endtask

  initial begin
    // Program A: sequential, branch taken/not taken, halt word, reset while halted
    step(0, 1, 0, 0, 0, 32'h3000, 32'h3C01_1234, 0);
    step(0, 0, 0, 0, 0, 32'h3004, 32'h3421_5678, 0);
    step(0, 0, 0, 0, 0, 32'h3008, 32'h1000_FFFE, 0);
    step(0, 0, 1, 1, 0, 32'h3004, 32'h3421_5678, 0);
    step(0, 0, 0, 0, 0, 32'h3008, 32'h1000_FFFE, 0);
    step(0, 0, 1, 0, 0, 32'h300C, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 0, 0, 32'h300C, 32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, i[0], 32'h300C, 32'h0, 1);
    end
    step(0, 1, 0, 0, 0, 32'h3000, 32'h3C01_1234, 0);
    step(0, 0, 0, 0, 0, 32'h3004, 32'h3421_5678, 0);

    // Program B: jumps, reset mid-run, out-of-range jump, reset while halted
    step(1, 1, 0, 0, 0, 32'h3000, 32'h0, 0);
    b_run_to_3020();
    step(1, 1, 0, 0, 0, 32'h3000, 32'h0, 0);
    b_run_to_3020();
    step(1, 0, 0, 0, 1, 32'h3020, 32'h0, 1);
    step(1, 0, 0, 0, 0, 32'h3020, 32'h0, 1);
    step(1, 1, 0, 0, 0, 32'h3000, 32'h0, 0);
    step(1, 0, 0, 0, 0, 32'h3004, 32'h0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
